// File: rtl/fifo_pkg.sv
// Shared helpers for the FWFT FIFO: counter and pointer widths, pointer wrap,
// and the read-path mode encodings.
package fifo_pkg;

  localparam int REG_OUT_COMB = 0;
  localparam int REG_OUT_REG  = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Explicit wrap so non-power-of-2 depths work.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one read port that is either
// combinational or registered (with load enable) depending on REG_OUT.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int REG_OUT    = REG_OUT_COMB,
  parameter int ADDR_W     = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  if (REG_OUT == REG_OUT_REG) begin : g_reg_rd
    // The read register doubles as the FIFO output register.
    always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end else begin : g_comb_rd
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
    assign rd_data      = mem[rd_addr];
  end

endmodule

// File: rtl/param_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with arbitrary depth, optional
// registered read path, threshold flags, flush, sticky errors and watermark.
module param_fwft_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 512,
  parameter int REG_OUT    = REG_OUT_COMB,
  parameter int AF_THRESH  = FIFO_DEPTH - 4,
  parameter int AE_THRESH  = 4,
  parameter int CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_status,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      used_w,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CNT_W-1:0]      peak_used
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc, ram_rd;

  assign full         = (used_w == CNT_W'(FIFO_DEPTH));
  assign almost_full  = (used_w >= CNT_W'(AF_THRESH));
  assign almost_empty = (used_w <= CNT_W'(AE_THRESH));

  // flush swallows both requests without raising error flags
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .REG_OUT    (REG_OUT),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  if (REG_OUT == REG_OUT_REG) begin : g_reg_out
    logic             out_valid;
    logic [CNT_W-1:0] mem_cnt;

    // used_w counts the output register too; memory holds the rest.
    assign mem_cnt = used_w - CNT_W'(out_valid);
    assign ram_rd  = !flush && (mem_cnt != '0) && (!out_valid || rd_acc);
    assign empty   = !out_valid;

    always_ff @(posedge clk) begin
      if (rst || flush)  out_valid <= 1'b0;
      else if (ram_rd)   out_valid <= 1'b1;
      else if (rd_acc)   out_valid <= 1'b0;
    end
  end else begin : g_comb_out
    assign ram_rd = rd_acc;
    assign empty  = (used_w == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used_w <= '0;
    end else begin
      if (wr_acc) wr_ptr <= PTR_W'(next_ptr(32'(wr_ptr), FIFO_DEPTH));
      if (ram_rd) rd_ptr <= PTR_W'(next_ptr(32'(rd_ptr), FIFO_DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   used_w <= used_w + CNT_W'(1);
        2'b01:   used_w <= used_w - CNT_W'(1);
        default: used_w <= used_w;
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      peak_used <= '0;
    end else begin
      overflow  <= (wr_en && full  && !flush) || (overflow  && !clr_status);
      underflow <= (rd_en && empty && !flush) || (underflow && !clr_status);
      if (used_w > peak_used) peak_used <= used_w;
      else if (clr_status)    peak_used <= '0;
    end
  end

endmodule

// File: tb/tb_param_fwft_fifo.sv
// Randomized scoreboard bench: one combinational-read and one registered-read
// FIFO share stimulus, each checked against a queue-level timing model.
module tb_param_fwft_fifo;

  localparam int DW = 16;
  localparam int D  = 6;
  localparam int AF = 4;
  localparam int AE = 2;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, clr_status = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0][DW-1:0] rd_data;
  logic [1:0][CW-1:0] used_w, peak_used;
  logic [1:0] full, empty, almost_full, almost_empty, overflow, underflow;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    param_fwft_fifo #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (D),
      .REG_OUT    (g),
      .AF_THRESH  (AF),
      .AE_THRESH  (AE)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .clr_status   (clr_status),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data[g]),
      .full         (full[g]),
      .empty        (empty[g]),
      .almost_full  (almost_full[g]),
      .almost_empty (almost_empty[g]),
      .used_w       (used_w[g]),
      .overflow     (overflow[g]),
      .underflow    (underflow[g]),
      .peak_used    (peak_used[g])
    );
  end

  // Model entry: data, edge it was written at, first cycle it may be shown.
  typedef struct {
    logic [DW-1:0] d;
    int            w;
    int            rdy;
  } ent_t;

  ent_t mb [2][D];
  int   hd  [2] = '{0, 0};
  int   cnt [2] = '{0, 0};
  int   pk  [2] = '{0, 0};
  bit   ovf [2] = '{0, 0};
  bit   unf [2] = '{0, 0};
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // An entry shows on the output once it is at the head and, for the
  // registered path, one extra edge has passed since it was written.
  always @(posedge clk) begin
    int e;
    e = cyc + 1;
    for (int m = 0; m < 2; m++) begin
      bit vis, ar, aw, newhead;
      vis = (cnt[m] > 0) && (mb[m][hd[m]].rdy <= cyc);
      if (rst) begin
        cnt[m] = 0; hd[m] = 0; pk[m] = 0; ovf[m] = 0; unf[m] = 0;
      end else begin
        ar = rd_en && vis && !flush;
        aw = wr_en && (cnt[m] < D) && !flush;
        pk[m]  = (cnt[m] > pk[m]) ? cnt[m] : (clr_status ? 0 : pk[m]);
        ovf[m] = (wr_en && cnt[m] == D && !flush) || (ovf[m] && !clr_status);
        unf[m] = (rd_en && !vis && !flush) || (unf[m] && !clr_status);
        if (flush) begin
          cnt[m] = 0; hd[m] = 0;
        end else begin
          newhead = ar || (cnt[m] == 0);
          if (ar) begin
            hd[m]  = (hd[m] + 1) % D;
            cnt[m] = cnt[m] - 1;
          end
          if (aw) begin
            mb[m][(hd[m] + cnt[m]) % D] = '{wr_data, e, 0};
            cnt[m] = cnt[m] + 1;
          end
          if (newhead && cnt[m] > 0)
            mb[m][hd[m]].rdy = (mb[m][hd[m]].w + m > e) ? mb[m][hd[m]].w + m : e;
        end
      end
    end
    cyc = e;
  end

  task automatic chk(input string name, input int m, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, m, cyc, act, exp);
    end
  endtask

  // Monitor: compare status every cycle; on each DUT read handshake the head
  // of the scoreboard must match rd_data.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit vis;
      vis = (cnt[m] > 0) && (mb[m][hd[m]].rdy <= cyc);
      chk("empty",        m, int'(empty[m]),        int'(!vis));
      chk("used_w",       m, int'(used_w[m]),       cnt[m]);
      chk("full",         m, int'(full[m]),         int'(cnt[m] == D));
      chk("almost_full",  m, int'(almost_full[m]),  int'(cnt[m] >= AF));
      chk("almost_empty", m, int'(almost_empty[m]), int'(cnt[m] <= AE));
      chk("overflow",     m, int'(overflow[m]),     int'(ovf[m]));
      chk("underflow",    m, int'(underflow[m]),    int'(unf[m]));
      chk("peak_used",    m, int'(peak_used[m]),    pk[m]);
      if (rd_en && !empty[m] && !flush && !rst) begin
        if (cnt[m] == 0) chk("rd_pop_nonempty", m, 0, 1);
        else             chk("rd_data", m, int'(rd_data[m]), int'(mb[m][hd[m]].d));
      end
    end
  end

  task automatic step(input bit w, input bit r, input bit f, input bit c);
    wr_en      = w;
    rd_en      = r;
    flush      = f;
    clr_status = c;
    wr_data    = DW'($urandom);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // single write then idle: latency of both read paths
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // overfill, drain past empty, then clear status
    repeat (D + 2) step(1, 0, 0, 0);
    repeat (D + 3) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    // flush with both requests pending
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      int ph, pw, pr;
      ph = (i / 100) % 4;
      pw = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 95 : 50;
      pr = (ph == 0) ? 20 : (ph == 1) ? 80 : (ph == 2) ? 95 : 50;
      if (i == 1500) begin
        rst = 1'b1;
        step(1, 1, 0, 0);
        rst = 1'b0;
      end
      step($urandom_range(99) < pw, $urandom_range(99) < pr,
           $urandom_range(59) == 0, $urandom_range(39) == 0);
    end
    repeat (2) step(0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_fwft_fifo.md
Name: param_fwft_fifo

Overview:
Next-generation single-clock first-word-fall-through (FWFT) FIFO for streaming datapaths between Avalon-style producers and consumers. It generalises the existing simple FIFO with:
- arbitrary (non-power-of-2) depth
- selectable combinational or registered read path, the latter for block-RAM inference and timing closure
- almost-full/almost-empty thresholds
- synchronous flush
- sticky overflow/underflow error flags
- peak-occupancy watermark

Parameters:
DATA_WIDTH, 32, width of each entry in bits (>=1)
FIFO_DEPTH, 512, number of entries (>=2, need not be a power of 2)
REG_OUT, 0, 0 = rd_data driven combinationally from memory at the read pointer; 1 = rd_data from an output register fed by a synchronous memory read
AF_THRESH, FIFO_DEPTH-4, almost_full asserts when used_w >= AF_THRESH
AE_THRESH, 4, almost_empty asserts when used_w <= AE_THRESH
CNT_W, $clog2(FIFO_DEPTH+1), width of the occupancy counters (derived; do not override)

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous clear of contents and pointers
clr_status  in  1  clears overflow, underflow and peak_used
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read acknowledge; consumes the entry currently on rd_data
rd_data  out  DATA_WIDTH  head-of-FIFO data, valid whenever empty=0
full  out  1  used_w == FIFO_DEPTH
empty  out  1  no entry presentable on rd_data
almost_full  out  1  used_w >= AF_THRESH
almost_empty  out  1  used_w <= AE_THRESH
used_w  out  CNT_W  entries held (memory plus output register)
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
peak_used  out  CNT_W  highest used_w since reset/clr_status

Behaviour:
- Reset (rst=1 at clk edge):
  - pointers, used_w and peak_used go to 0; overflow and underflow go to 0.
  - Output-register valid goes to 0, so empty=1 and full=0.
  - almost_empty=1; almost_full=(0>=AF_THRESH).
  - rd_data is don't-care while empty. Memory contents are not reset.
- Write accepted iff wr_en && !full. A write while full is dropped, sets overflow, and leaves used_w unchanged.
- Read accepted iff rd_en && !empty. A read while empty is ignored and sets underflow.
- Simultaneous accepted read and write: used_w unchanged, both pointers advance. When full, a write is rejected even if a read is accepted the same cycle.
- Pointer wrap: each pointer goes FIFO_DEPTH-1 -> 0 explicitly; no reliance on power-of-2 overflow.
- used_w: +1 on write-only, -1 on read-only, otherwise held. It never exceeds FIFO_DEPTH and never underflows.
- REG_OUT=0:
  - rd_data = mem[rd_ptr]; empty = (used_w==0).
  - Write-to-visible latency is 1 cycle: empty falls the cycle after the write edge.
- REG_OUT=1:
  - The memory has a registered read port. A prefetch path loads the output register whenever it is empty, or is being consumed and memory holds data.
  - empty = !out_valid.
  - Write into an empty FIFO reaches rd_data 2 cycles after the write edge; used_w increments after 1 cycle.
  - Back-to-back reads sustain 1 entry/cycle with no bubbles once primed. A skid/prefetch of one word is required.
  - Ordering is strictly FIFO in both modes.
- almost_full and almost_empty are combinational from used_w.
- flush:
  - On the next edge, pointers, used_w and out_valid clear.
  - Overrides wr_en/rd_en in the same cycle: both are dropped and set no error flags.
  - Does not clear overflow, underflow or peak_used.
  - rst has priority over flush.
- clr_status: clears overflow, underflow and peak_used on the next edge. If an error condition or a new peak occurs in the same cycle, the set wins.
- peak_used updates to the new used_w whenever it exceeds the stored value (registered, 1 cycle after used_w).

Decomposition:
- Shared package fifo_pkg:
  - function for counter width (clog2 of depth+1)
  - function for next-pointer wrap
  - localparams for the REG_OUT mode encodings
- One sub-module, fifo_ram: simple dual-port RAM with a write port and a read port that is combinational or registered according to REG_OUT. It keeps inference portable across vendors.
- Top level holds pointers, counters, prefetch/out_valid logic and flags.

Test Plan:
1. REG_OUT=0, DEPTH=5: write 5 words 0xA0..0xA4 -> full=1 and used_w=5. Write 0xFF -> dropped, overflow=1. Read 5 -> 0xA0..0xA4 in order, empty=1.
2. REG_OUT=1, DEPTH=8: single write 0x55 at cycle t -> used_w=1 at t+1, empty=0 and rd_data=0x55 at t+2. Then 20 continuous writes with continuous rd_en -> data in order, no gap after priming.
3. DEPTH=6, 14 writes interleaved with reads keeping occupancy 3..6 -> pointer wrap exercised, output sequence identical to input sequence.
4. AF_THRESH=6, AE_THRESH=2, DEPTH=8: fill 0->8 -> almost_empty clears at used_w=3, almost_full sets at used_w=6. Drain -> mirror transitions.
5. Fill 4 entries, then assert flush with wr_en=rd_en=1 -> next cycle used_w=0, empty=1, no flag change. Read while empty -> underflow=1. clr_status -> underflow=0, peak_used=0.
6. Assert rst mid-stream (used_w=3, overflow=1) -> next edge: all outputs at reset values. Traffic resumes correctly from the first subsequent write.
